// File: rtl/plot_pkg.sv
// Shared types, screen geometry and address mapping for the plot capture block.
package plot_pkg;

  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned FB_DEPTH = 19200;
  localparam int unsigned FB_AW    = 15;

  typedef logic [X_W-1:0]   x_t;
  typedef logic [Y_W-1:0]   y_t;
  typedef logic [2:0]       colour_t;
  typedef logic [FB_AW-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Row-major linear address: y*160 + x using shifts only.
  function automatic addr_t xy_to_addr(input x_t x, input y_t y);
    return (addr_t'(y) << 7) + (addr_t'(y) << 5) + addr_t'(x);
  endfunction

endpackage

// File: rtl/plot_if.sv
// Plot stream, clear control, readback and statistics bundle.
interface plot_if
  import plot_pkg::*;
#(
  parameter int unsigned SAT_W    = 16,
  parameter int unsigned COLOUR_W = 3
);
  x_t                  vga_x;
  y_t                  vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;
  logic                clr_start;
  logic                clr_done;
  logic                busy;
  logic                rd_req;
  x_t                  rd_x;
  y_t                  rd_y;
  logic                rd_valid;
  logic [COLOUR_W-1:0] rd_colour;
  logic [SAT_W-1:0]    plot_count;
  logic [SAT_W-1:0]    oob_count;
  logic [SAT_W-1:0]    drop_count;
  logic                bbox_valid;
  x_t                  bbox_min_x;
  x_t                  bbox_max_x;
  y_t                  bbox_min_y;
  y_t                  bbox_max_y;

  modport master (
    output vga_x, vga_y, vga_colour, vga_plot, clr_start, rd_req, rd_x, rd_y,
    input  clr_done, busy, rd_valid, rd_colour, plot_count, oob_count, drop_count,
           bbox_valid, bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y
  );

  modport slave (
    input  vga_x, vga_y, vga_colour, vga_plot, clr_start, rd_req, rd_x, rd_y,
    output clr_done, busy, rd_valid, rd_colour, plot_count, oob_count, drop_count,
           bbox_valid, bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y
  );
endinterface

// File: rtl/fb_ram.sv
// Simple dual-port frame buffer; a colliding read returns the pre-write data.
module fb_ram #(
  parameter int unsigned AW    = 15,
  parameter int unsigned DEPTH = 19200,
  parameter int unsigned DW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  // Write and read on the same edge; non-blocking update gives read-old-data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/plot_capture.sv
// Captures plotted pixels into a frame buffer, runs a clear sequencer and keeps plot statistics.
module plot_capture
  import plot_pkg::*;
#(
  parameter int unsigned SAT_W    = 16,
  parameter int unsigned COLOUR_W = 3
) (
  input  logic  clk,
  input  logic  rst_n,
  plot_if.slave bus
);
  localparam logic [SAT_W-1:0] SAT_MAX = {SAT_W{1'b1}};

  state_t              state, state_nxt;
  addr_t               clr_addr;
  logic                in_range_c, accept_c, drop_c, oob_c, enter_clr_c, clr_last_c;
  logic                rd_in_range_c, rd_hit;
  logic                we_c;
  addr_t               waddr_c;
  logic [COLOUR_W-1:0] wdata_c;
  logic [COLOUR_W-1:0] ram_q;

  assign in_range_c    = (bus.vga_x < x_t'(SCREEN_W)) && (bus.vga_y < y_t'(SCREEN_H));
  assign rd_in_range_c = (bus.rd_x < x_t'(SCREEN_W)) && (bus.rd_y < y_t'(SCREEN_H));
  assign accept_c      = bus.vga_plot && in_range_c && (state != CLEAR);
  assign drop_c        = bus.vga_plot && in_range_c && (state == CLEAR);
  assign oob_c         = bus.vga_plot && !in_range_c;
  assign enter_clr_c   = (state == IDLE) && bus.clr_start;
  assign clr_last_c    = (clr_addr == addr_t'(FB_DEPTH - 1));

  // Next state and frame-buffer write mux (clear sweep vs accepted plot).
  always_comb begin
    state_nxt = state;
    we_c      = 1'b0;
    waddr_c   = xy_to_addr(bus.vga_x, bus.vga_y);
    wdata_c   = bus.vga_colour;
    case (state)
      IDLE: begin
        we_c = accept_c;
        if (bus.clr_start) state_nxt = CLEAR;
      end
      CLEAR: begin
        we_c    = 1'b1;
        waddr_c = clr_addr;
        wdata_c = '0;
        if (clr_last_c) state_nxt = DONE;
      end
      DONE: begin
        we_c = accept_c;
        if (!bus.clr_start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register with registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bus.busy     <= 1'b0;
      bus.clr_done <= 1'b0;
    end else begin
      state        <= state_nxt;
      bus.busy     <= (state_nxt == CLEAR);
      bus.clr_done <= (state_nxt == DONE);
    end
  end

  // Clear address sweeps 0..FB_DEPTH-1 while clearing, parked at 0 otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              clr_addr <= '0;
    else if (state == CLEAR) clr_addr <= clr_addr + addr_t'(1);
    else                     clr_addr <= '0;
  end

  // Saturating statistics; starting a clear wins over a same-cycle plot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.plot_count <= '0;
      bus.drop_count <= '0;
      bus.oob_count  <= '0;
    end else begin
      if (enter_clr_c) begin
        bus.plot_count <= '0;
        bus.drop_count <= '0;
      end else begin
        if (accept_c && bus.plot_count != SAT_MAX) bus.plot_count <= bus.plot_count + 1'b1;
        if (drop_c && bus.drop_count != SAT_MAX)   bus.drop_count <= bus.drop_count + 1'b1;
      end
      if (oob_c && bus.oob_count != SAT_MAX) bus.oob_count <= bus.oob_count + 1'b1;
    end
  end

  // Bounding box of accepted plots since reset or the last clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.bbox_valid <= 1'b0;
      bus.bbox_min_x <= '0;
      bus.bbox_max_x <= '0;
      bus.bbox_min_y <= '0;
      bus.bbox_max_y <= '0;
    end else if (enter_clr_c) begin
      bus.bbox_valid <= 1'b0;
    end else if (accept_c) begin
      bus.bbox_valid <= 1'b1;
      if (!bus.bbox_valid) begin
        bus.bbox_min_x <= bus.vga_x;
        bus.bbox_max_x <= bus.vga_x;
        bus.bbox_min_y <= bus.vga_y;
        bus.bbox_max_y <= bus.vga_y;
      end else begin
        if (bus.vga_x < bus.bbox_min_x) bus.bbox_min_x <= bus.vga_x;
        if (bus.vga_x > bus.bbox_max_x) bus.bbox_max_x <= bus.vga_x;
        if (bus.vga_y < bus.bbox_min_y) bus.bbox_min_y <= bus.vga_y;
        if (bus.vga_y > bus.bbox_max_y) bus.bbox_max_y <= bus.vga_y;
      end
    end
  end

  // Readback qualifiers aligned with the one-cycle RAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_valid <= 1'b0;
      rd_hit       <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_req;
      rd_hit       <= bus.rd_req && rd_in_range_c;
    end
  end

  // Out-of-range or idle reads present colour 0.
  assign bus.rd_colour = rd_hit ? ram_q : '0;

  fb_ram #(
    .AW   (FB_AW),
    .DEPTH(FB_DEPTH),
    .DW   (COLOUR_W)
  ) u_fb_ram (
    .clk  (clk),
    .we   (we_c),
    .waddr(waddr_c),
    .wdata(wdata_c),
    .raddr(xy_to_addr(bus.rd_x, bus.rd_y)),
    .rdata(ram_q)
  );
endmodule

// File: tb/tb_plot_capture.sv
// Randomised and directed checks of plot_capture against a behavioural frame/statistics model.
module tb_plot_capture;
  localparam int SATW   = 8;
  localparam int SATMAX = 255;
  localparam int NPIX   = 160 * 120;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   chk_on = 0;

  plot_if #(.SAT_W(SATW), .COLOUR_W(3)) bus ();

  plot_capture #(.SAT_W(SATW), .COLOUR_W(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model state: pixel memory, which pixels are defined, and plain-number statistics.
  logic [2:0] m_fb    [NPIX];
  bit         m_known [NPIX];
  int m_mode = 0;  // 0 waiting, 1 clearing, 2 clear finished
  int m_left = 0;
  int m_plots = 0, m_oob = 0, m_drop = 0;
  bit m_bv = 0;
  int m_minx = 0, m_maxx = 0, m_miny = 0, m_maxy = 0;
  bit m_rv = 0, m_rchk = 0;
  int m_rcol = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < SATMAX) ? v + 1 : v;
  endfunction

  // Behavioural reference, advanced once per clock from the sampled inputs.
  always @(posedge clk or negedge rst_n) begin
    int a, x, y;
    if (!rst_n) begin
      if (m_mode == 1) for (int i = 0; i < NPIX; i++) m_known[i] = 0;
      m_mode = 0; m_left = 0;
      m_plots = 0; m_oob = 0; m_drop = 0;
      m_bv = 0; m_minx = 0; m_maxx = 0; m_miny = 0; m_maxy = 0;
      m_rv = 0; m_rchk = 0; m_rcol = 0;
    end else begin
      m_rv = bus.rd_req; m_rchk = 0; m_rcol = 0;
      if (bus.rd_req) begin
        x = int'(bus.rd_x); y = int'(bus.rd_y);
        if (x < 160 && y < 120) begin
          a = y * 160 + x;
          if (m_mode != 1 && m_known[a]) begin m_rchk = 1; m_rcol = int'(m_fb[a]); end
        end else begin
          m_rchk = 1; m_rcol = 0;
        end
      end
      if (bus.vga_plot) begin
        x = int'(bus.vga_x); y = int'(bus.vga_y);
        if (x >= 160 || y >= 120) m_oob = sat_inc(m_oob);
        else if (m_mode == 1) m_drop = sat_inc(m_drop);
        else begin
          a = y * 160 + x;
          m_fb[a] = bus.vga_colour; m_known[a] = 1;
          m_plots = sat_inc(m_plots);
          if (!m_bv) begin m_minx = x; m_maxx = x; m_miny = y; m_maxy = y; end
          else begin
            if (x < m_minx) m_minx = x;
            if (x > m_maxx) m_maxx = x;
            if (y < m_miny) m_miny = y;
            if (y > m_maxy) m_maxy = y;
          end
          m_bv = 1;
        end
      end
      case (m_mode)
        0: if (bus.clr_start) begin
             m_mode = 1; m_left = NPIX; m_plots = 0; m_drop = 0; m_bv = 0;
           end
        1: begin
             m_left--;
             if (m_left == 0) begin
               m_mode = 2;
               for (int i = 0; i < NPIX; i++) begin m_fb[i] = 3'd0; m_known[i] = 1; end
             end
           end
        default: if (!bus.clr_start) m_mode = 0;
      endcase
    end
  end

  // Cycle-by-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", int'(bus.busy), int'(m_mode == 1));
      chk("clr_done", int'(bus.clr_done), int'(m_mode == 2));
      chk("plot_count", int'(bus.plot_count), m_plots);
      chk("oob_count", int'(bus.oob_count), m_oob);
      chk("drop_count", int'(bus.drop_count), m_drop);
      chk("bbox_valid", int'(bus.bbox_valid), int'(m_bv));
      if (m_bv) begin
        chk("bbox_min_x", int'(bus.bbox_min_x), m_minx);
        chk("bbox_max_x", int'(bus.bbox_max_x), m_maxx);
        chk("bbox_min_y", int'(bus.bbox_min_y), m_miny);
        chk("bbox_max_y", int'(bus.bbox_max_y), m_maxy);
      end
      chk("rd_valid", int'(bus.rd_valid), int'(m_rv));
      if (m_rv && m_rchk) chk("rd_colour", int'(bus.rd_colour), m_rcol);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic plot(input int x, input int y, input int c);
    bus.vga_x = 8'(x); bus.vga_y = 7'(y); bus.vga_colour = 3'(c); bus.vga_plot = 1'b1;
    step();
    bus.vga_plot = 1'b0;
  endtask

  task automatic rd(input int x, input int y, output int c);
    bus.rd_x = 8'(x); bus.rd_y = 7'(y); bus.rd_req = 1'b1;
    step();
    bus.rd_req = 1'b0;
    c = int'(bus.rd_colour);
  endtask

  // Clear with clr_start held until done; optional single plot at a given busy cycle.
  task automatic run_clear(input int plot_at, output int n);
    int guard;
    n = 0; guard = 0;
    bus.clr_start = 1'b1;
    while (!bus.clr_done && guard < 25000) begin
      if (bus.busy && n == plot_at) begin
        bus.vga_x = 8'd5; bus.vga_y = 7'd5; bus.vga_colour = 3'd7; bus.vga_plot = 1'b1;
      end else bus.vga_plot = 1'b0;
      step();
      guard++;
      if (bus.busy) n++;
    end
    bus.vga_plot = 1'b0;
    if (!bus.clr_done) chk("clear_timeout", 0, 1);
    bus.clr_start = 1'b0;
    step(); step();
  endtask

  task automatic random_phase(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      bus.vga_plot   = ($urandom_range(0, 9) < 7);
      bus.vga_x      = 8'($urandom_range(0, 199));
      bus.vga_y      = 7'($urandom_range(0, 127));
      bus.vga_colour = 3'($urandom_range(0, 7));
      bus.rd_req     = ($urandom_range(0, 1) == 1);
      bus.rd_x       = 8'($urandom_range(0, 170));
      bus.rd_y       = 7'($urandom_range(0, 125));
      step();
    end
    bus.vga_plot = 1'b0; bus.rd_req = 1'b0;
    step();
  endtask

  initial begin
    int n, c, guard;
    bus.vga_x = '0; bus.vga_y = '0; bus.vga_colour = '0; bus.vga_plot = 1'b0;
    bus.clr_start = 1'b0; bus.rd_req = 1'b0; bus.rd_x = '0; bus.rd_y = '0;
    step(); step();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_clr_done", int'(bus.clr_done), 0);
    chk("rst_rd_valid", int'(bus.rd_valid), 0);
    chk("rst_rd_colour", int'(bus.rd_colour), 0);
    chk("rst_counts", int'(bus.plot_count) + int'(bus.oob_count) + int'(bus.drop_count), 0);
    chk("rst_bbox", int'(bus.bbox_valid) + int'(bus.bbox_max_x) + int'(bus.bbox_max_y), 0);
    rst_n = 1'b1;
    step();
    chk_on = 1;

    run_clear(-1, n);
    chk("clear_busy_cycles", n, 19200);
    rd(0, 0, c);     chk("rd_0_0", c, 0);
    rd(159, 119, c); chk("rd_159_119", c, 0);
    rd(80, 60, c);   chk("rd_80_60", c, 0);

    plot(10, 20, 5);
    plot(150, 100, 3);
    rd(10, 20, c);   chk("rd_10_20", c, 5);
    rd(150, 100, c); chk("rd_150_100", c, 3);
    chk("plot_count_2", int'(bus.plot_count), 2);
    chk("bbox_lit", int'(bus.bbox_min_x) * 1000000 + int'(bus.bbox_max_x) * 1000
        + int'(bus.bbox_min_y) * 10 + int'(bus.bbox_max_y) / 10, 10150210);
    chk("bbox_valid_lit", int'(bus.bbox_valid), 1);

    plot(160, 0, 1);
    plot(0, 120, 1);
    step();
    chk("oob_count_2", int'(bus.oob_count), 2);
    chk("plot_count_kept", int'(bus.plot_count), 2);
    rd(159, 0, c);   chk("rd_159_0", c, 0);

    bus.vga_x = 8'd3; bus.vga_y = 7'd3; bus.vga_colour = 3'd6; bus.vga_plot = 1'b1;
    bus.rd_x = 8'd3; bus.rd_y = 7'd3; bus.rd_req = 1'b1;
    step();
    bus.vga_plot = 1'b0; bus.rd_req = 1'b0;
    chk("collide_old", int'(bus.rd_colour), 0);
    rd(3, 3, c);     chk("collide_new", c, 6);

    random_phase(3000);
    chk("plot_count_sat", int'(bus.plot_count), SATMAX);
    chk("oob_count_sat", int'(bus.oob_count), SATMAX);

    run_clear(100, n);
    chk("clear2_busy_cycles", n, 19200);
    chk("drop_count_1", int'(bus.drop_count), 1);
    chk("plot_count_after_clear", int'(bus.plot_count), 0);
    rd(5, 5, c);     chk("rd_5_5_dropped", c, 0);

    bus.clr_start = 1'b1;
    n = 0; guard = 0;
    while (n < 5000 && guard < 25000) begin
      step(); guard++;
      if (bus.busy) n++;
    end
    chk("reached_5000", n, 5000);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_oob", int'(bus.oob_count), 0);
    chk("midrst_plot", int'(bus.plot_count), 0);
    chk("midrst_drop", int'(bus.drop_count), 0);
    chk("midrst_bbox_valid", int'(bus.bbox_valid), 0);
    bus.clr_start = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    run_clear(-1, n);
    chk("clear3_busy_cycles", n, 19200);
    rd(159, 119, c); chk("rd_after_clear3", c, 0);

    random_phase(500);
    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/plot_capture.md
# plot_capture

Pixel-stream sink for the 160×120, 3-bit-colour plot interface that our drawing engines (fillscreen, circle, Reuleaux) drive. It captures every plotted pixel into an on-chip frame buffer and keeps running statistics (plot count, out-of-range count, bounding box). It provides a synchronous readback port so benches and a future scan-out path can inspect the drawn image. It sits where the VGA adapter would: drawing engine plot outputs → plot_capture.

## Interface
Parameters
- SAT_W, 16, width of saturating counters
- COLOUR_W, 3, colour bits per pixel

Ports
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- vga_x  in  8  plot column
- vga_y  in  7  plot row
- vga_colour  in  3  plot colour
- vga_plot  in  1  write strobe; one pixel per cycle high
- clr_start  in  1  request frame-buffer clear to colour 0
- clr_done  out  1  clear finished; held until clr_start low
- busy  out  1  high while clearing
- rd_req  in  1  readback request
- rd_x  in  8  readback column
- rd_y  in  7  readback row
- rd_valid  out  1  rd_colour valid
- rd_colour  out  3  readback data
- plot_count  out  SAT_W  accepted plots, saturating
- oob_count  out  SAT_W  plots with x≥160 or y≥120, saturating
- drop_count  out  SAT_W  in-range plots discarded during clear, saturating
- bbox_valid  out  1  at least one plot accepted since reset/clear
- bbox_min_x, bbox_max_x  out  8 each  bounding box columns
- bbox_min_y, bbox_max_y  out  7 each  bounding box rows

## Operation
- Address = y·160 + x = (y<<7)+(y<<5)+x, 15 bits; depth 19200.
- Plot accepted when vga_plot=1, x<160, y<120, state IDLE/DONE: write colour, plot_count+1, update bbox (first accepted plot loads min=max=coordinate, sets bbox_valid).
- vga_plot=1 with x≥160 or y≥120: no write, oob_count+1 (in any state).
- In-range plot during CLEAR: no write, drop_count+1.
- FSM: IDLE → CLEAR on clr_start=1. CLEAR writes 0 to address 0…19199, one per cycle. After address 19199: → DONE. DONE: clr_done=1; → IDLE when clr_start=0.
- Entering CLEAR zeroes plot_count and drop_count, and clears bbox_valid. oob_count is zeroed by reset only.
- busy = (state==CLEAR).
- Counters stop at 2^SAT_W−1.
- Readback: rd_req with in-range coordinate returns stored colour; out-of-range returns 0. Reads are permitted in every state. A read and a write to the same address in the same cycle return the old data.
- Frame-buffer contents are not reset; the image is defined only after a completed clear.

## Timing
- Reset values: state IDLE, clr_done 0, busy 0, rd_valid 0, rd_colour 0, all counters 0, bbox_valid 0, bbox fields 0.
- Write commits at the clock edge sampling vga_plot=1. It is visible to a rd_req issued on the following cycle.
- Counter and bbox updates are visible 1 cycle after the sampling edge.
- Read latency 1: rd_valid=1 the cycle after rd_req. Back-to-back reads give one result per cycle.
- Clear: busy rises 1 cycle after clr_start is sampled. Duration 19200 cycles. clr_done rises the cycle after the last write.
- clr_start held high in DONE does not restart the clear; it must fall and rise again.
- Reset mid-clear: immediately return to IDLE. The buffer is left partially cleared.

## Structure
- Package plot_pkg: SCREEN_W=160, SCREEN_H=120, FB_DEPTH=19200, FB_AW=15, typedefs for x_t (8b), y_t (7b), colour_t (3b), addr_t, state enum {IDLE, CLEAR, DONE}, and an address function xy_to_addr.
- Sub-module fb_ram: one synchronous write port, one synchronous read port, returns old data on read/write collision. Infers M10K; no reset.
- plot_capture holds the FSM, clear address counter, statistics and the write mux (clear vs plot).

## Test plan
- Reset, clr_start pulse held until clr_done → busy for exactly 19200 cycles. Read (0,0), (159,119), (80,60) → all 0.
- After clear, plot (10,20,c=5), (150,100,c=3). Read both next cycle → 5, 3. plot_count=2, bbox=(10..150, 20..100), bbox_valid=1.
- Plot (160,0) and (0,120) → oob_count=2, plot_count unchanged. Read (159,0) is unaffected.
- Start clear, plot (5,5,c=7) mid-clear → drop_count=1. After done, read (5,5) → 0.
- Same-cycle plot (3,3,c=6) and rd_req (3,3) → old value 0. rd_req next cycle → 6.
- Assert rst_n=0 at clear cycle 5000 → busy=0 and all counters 0 immediately. A new clear then completes in 19200 cycles.
